// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

    localparam int REG_W_DEF = 5;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_BUBBLE   = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_HALT     = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable, synchronous clear and async active-low clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Count up on enable, hold at all-ones; sync clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (en_i && (cnt_q != '1))
            cnt_q <= cnt_q + W'(1);
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller: stage write enables (combinational) and
// registered load-NOP flushes for a 5-stage pipeline.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W    = REG_W_DEF,
    parameter int WAIT_MAX = 64,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             ex_branch_taken,
    input  logic             exmem_memreq,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [2:0]       state
);

    localparam int WC_W = $clog2(WAIT_MAX + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);

    ctrl_state_e     state_q, state_d;
    logic            ifid_flush_q, ifid_flush_d;
    logic            idex_flush_q, idex_flush_d;
    logic            memwb_flush_q, memwb_flush_d;
    logic            timeout_q, timeout_d;

    logic            wait_c, lu_c;
    logic            pc_we_c, ifid_we_c, idex_we_c, exmem_we_c, memwb_we_c;
    logic            wcnt_en, wcnt_clr;
    logic [WC_W-1:0] wcnt;

    // Hazard conditions; register zero never creates a dependency.
    assign wait_c = exmem_memreq & ~dmem_ready;
    assign lu_c   = idex_memread & (idex_rt != '0) &
                    ((id_rs_used & (id_rs == idex_rt)) |
                     (id_rt_used & (id_rt == idex_rt)));

    // Next-state and enable decode: wait > branch > load-use (load-use ignored in REDIRECT).
    always_comb begin
        state_d       = ST_RUN;
        pc_we_c       = 1'b1;
        ifid_we_c     = 1'b1;
        idex_we_c     = 1'b1;
        exmem_we_c    = 1'b1;
        memwb_we_c    = 1'b1;
        ifid_flush_d  = 1'b0;
        idex_flush_d  = 1'b0;
        memwb_flush_d = 1'b0;
        timeout_d     = timeout_q;
        wcnt_en       = 1'b0;
        wcnt_clr      = 1'b1;
        if (state_q == ST_HALT) begin
            state_d    = ST_HALT;
            pc_we_c    = 1'b0;
            ifid_we_c  = 1'b0;
            idex_we_c  = 1'b0;
            exmem_we_c = 1'b0;
            memwb_we_c = 1'b0;
            wcnt_clr   = 1'b0;
        end else if (wait_c) begin
            // Freeze everything upstream of MEM; let MEM/WB take a NOP.
            pc_we_c    = 1'b0;
            ifid_we_c  = 1'b0;
            idex_we_c  = 1'b0;
            exmem_we_c = 1'b0;
            wcnt_clr   = 1'b0;
            wcnt_en    = 1'b1;
            if (wcnt == WAIT_LAST) begin
                state_d   = ST_HALT;
                timeout_d = 1'b1;
            end else begin
                state_d       = ST_MEM_WAIT;
                memwb_flush_d = 1'b1;
            end
        end else if (ex_branch_taken) begin
            // PC takes the target; the two younger instructions are squashed.
            state_d      = ST_REDIRECT;
            ifid_flush_d = 1'b1;
            idex_flush_d = 1'b1;
        end else if (lu_c && (state_q != ST_REDIRECT)) begin
            state_d      = ST_BUBBLE;
            pc_we_c      = 1'b0;
            ifid_we_c    = 1'b0;
            idex_flush_d = 1'b1;
        end
    end

    // State and flush registers.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q       <= ST_RUN;
            ifid_flush_q  <= 1'b0;
            idex_flush_q  <= 1'b0;
            memwb_flush_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ifid_flush_q  <= ifid_flush_d;
            idex_flush_q  <= idex_flush_d;
            memwb_flush_q <= memwb_flush_d;
            timeout_q     <= timeout_d;
        end
    end

    // Consecutive memory-wait cycles; cleared by any non-wait cycle.
    sat_counter #(.W(WC_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (areset_n),
        .clr_i (wcnt_clr),
        .en_i  (wcnt_en),
        .cnt_o (wcnt)
    );

    // Cycles in which the PC did not advance.
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (areset_n),
        .clr_i (1'b0),
        .en_i  (~pc_we_c),
        .cnt_o (stall_cycles)
    );

    // Enables are held off for the whole reset assertion.
    assign pc_we       = areset_n & pc_we_c;
    assign ifid_we     = areset_n & ifid_we_c;
    assign idex_we     = areset_n & idex_we_c;
    assign exmem_we    = areset_n & exmem_we_c;
    assign memwb_we    = areset_n & memwb_we_c;
    assign ifid_flush  = ifid_flush_q;
    assign idex_flush  = idex_flush_q;
    assign memwb_flush = memwb_flush_q;
    assign mem_timeout = timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (WAIT_MAX=4, CNT_W=4 to reach timeout and saturation).
module tb_pipe_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             areset_n = 1'b0;
    logic [REG_W-1:0] id_rs, id_rt, idex_rt;
    logic             id_rs_used, id_rt_used, idex_memread;
    logic             ex_branch_taken, exmem_memreq, dmem_ready;
    logic             pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic             ifid_flush, idex_flush, memwb_flush, mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [2:0]       state;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(REG_W), .WAIT_MAX(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .areset_n(areset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .ex_branch_taken(ex_branch_taken),
        .exmem_memreq(exmem_memreq), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; idex_rt = '0;
        id_rs_used = 0; id_rt_used = 0; idex_memread = 0;
        ex_branch_taken = 0; exmem_memreq = 0; dmem_ready = 0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // Assert reset mid-cycle, check reset values, release away from an edge.
    task automatic do_reset();
        #2 areset_n = 0;
        #1;
        chk("rst_pc_we", pc_we, 0);
        chk("rst_memwb_we", memwb_we, 0);
        chk("rst_state", state, 0);
        chk("rst_flush", {ifid_flush, idex_flush, memwb_flush}, 0);
        chk("rst_timeout", mem_timeout, 0);
        chk("rst_stall", stall_cycles, 0);
        idle();
        @(negedge clk);
        areset_n = 1;
        cyc();
    endtask

    task automatic set_lu(input logic [REG_W-1:0] rt);
        idex_memread = 1; idex_rt = rt; id_rs = 5'd8; id_rs_used = 1;
    endtask

    initial begin
        idle();
        #12;
        chk("init_pc_we", pc_we, 0);
        @(negedge clk);
        areset_n = 1;
        cyc();

        // Load-use on rs: one bubble.
        set_lu(5'd8);
        #3;
        chk("lu_pc_we", pc_we, 0);
        chk("lu_ifid_we", ifid_we, 0);
        chk("lu_idex_we", {idex_we, exmem_we, memwb_we}, 3'b111);
        cyc(); idle(); #3;
        chk("lu_idex_flush", idex_flush, 1);
        chk("lu_state_bubble", state, 1);
        chk("lu_pc_we_after", pc_we, 1);
        cyc();
        chk("lu_flush_drop", idex_flush, 0);
        chk("lu_state_run", state, 0);
        chk("lu_stall", stall_cycles, 1);

        // Load-use via rt only.
        idex_memread = 1; idex_rt = 5'd3; id_rt = 5'd3; id_rt_used = 1;
        #3;
        chk("lu_rt_pc_we", pc_we, 0);
        cyc(); idle();
        chk("lu_rt_state", state, 1);
        cyc();

        // Register zero and unused source never stall.
        idex_memread = 1; idex_rt = 5'd0; id_rs = 5'd0; id_rs_used = 1;
        #3;
        chk("r0_we", {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, 5'b11111);
        cyc();
        id_rs_used = 0; id_rs = 5'd9; idex_rt = 5'd9;
        #3;
        chk("unused_pc_we", pc_we, 1);
        cyc(); idle();
        chk("r0_state", state, 0);
        chk("r0_flush", idex_flush, 0);
        chk("r0_stall", stall_cycles, 2);

        // Branch together with load-use: branch wins, no bubble.
        do_reset();
        set_lu(5'd8); ex_branch_taken = 1;
        #3;
        chk("br_we", {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, 5'b11111);
        cyc();
        ex_branch_taken = 0;           // lu still present, ignored in REDIRECT
        #3;
        chk("br_flush", {ifid_flush, idex_flush, memwb_flush}, 3'b110);
        chk("br_state", state, 2);
        chk("redir_ignores_lu", pc_we, 1);
        cyc(); idle();
        chk("br_flush_drop", {ifid_flush, idex_flush}, 0);
        chk("br_state_run", state, 0);
        chk("br_stall", stall_cycles, 0);

        // 3-cycle memory wait with branch held; redirect on ready cycle.
        do_reset();
        exmem_memreq = 1; dmem_ready = 0; ex_branch_taken = 1;
        #3;
        chk("mw1_we", {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, 5'b00001);
        chk("mw1_mflush", memwb_flush, 0);
        cyc(); #3;
        chk("mw2_mflush", memwb_flush, 1);
        chk("mw2_state", state, 3);
        chk("mw2_pc_we", pc_we, 0);
        cyc(); #3;
        chk("mw3_mflush", memwb_flush, 1);
        chk("mw3_pc_we", pc_we, 0);
        cyc();
        dmem_ready = 1; #3;
        chk("mw4_mflush", memwb_flush, 1);
        chk("mw4_we", {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, 5'b11111);
        cyc(); idle(); #3;
        chk("mw5_flush", {ifid_flush, idex_flush, memwb_flush}, 3'b110);
        chk("mw5_state", state, 2);
        chk("mw_stall", stall_cycles, 3);

        // Wait counter clears on a non-wait cycle: 3 + ready + 3 does not halt.
        exmem_memreq = 1; dmem_ready = 0;
        cyc(); cyc(); cyc();
        dmem_ready = 1; cyc();
        dmem_ready = 0; cyc(); cyc(); cyc();
        chk("wclr_state", state, 3);
        chk("wclr_timeout", mem_timeout, 0);
        idle(); cyc();

        // Reset in the middle of a wait, then counter restarts from zero.
        do_reset();
        exmem_memreq = 1; dmem_ready = 0;
        cyc(); cyc(); #2;
        areset_n = 0; #1;
        chk("mrst_state", state, 0);
        chk("mrst_mflush", memwb_flush, 0);
        chk("mrst_we", {pc_we, memwb_we}, 0);
        chk("mrst_stall", stall_cycles, 0);
        @(negedge clk);
        areset_n = 1;
        cyc(); cyc();
        chk("mrst_after_state", state, 3);
        cyc();
        chk("mrst_no_halt", state, 3);
        idle(); cyc();

        // Timeout: 4th consecutive wait cycle enters HALT.
        do_reset();
        exmem_memreq = 1; dmem_ready = 0;
        cyc(); cyc(); cyc();
        chk("to_pre_state", state, 3);
        chk("to_pre_timeout", mem_timeout, 0);
        cyc();
        chk("to_state", state, 4);
        chk("to_timeout", mem_timeout, 1);
        chk("to_we", {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, 0);
        chk("to_flush", {ifid_flush, idex_flush, memwb_flush}, 0);
        idle(); dmem_ready = 1; ex_branch_taken = 1; #1;
        chk("halt_ignores_br", pc_we, 0);
        for (int i = 0; i < 16; i++) cyc();
        chk("halt_state", state, 4);
        chk("halt_stall_sat", stall_cycles, 4'hF);
        chk("halt_timeout", mem_timeout, 1);
        do_reset();
        chk("post_rst_state", state, 0);
        chk("post_rst_pc_we", pc_we, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
